// File: rtl/jk_counter_pkg.sv
// Shared JK command encodings and the modulo next-count helper
// for the jk_sync_counter slice.
package jk_counter_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Out-of-range states fall back to 0 in either direction.
    function automatic logic [31:0] next_count(
        input logic [31:0] q,
        input logic        up_down,
        input logic [31:0] modulus
    );
        if (q >= modulus) begin
            return '0;
        end
        if (up_down) begin
            return (q == modulus - 1) ? '0 : q + 1;
        end
        return (q == '0) ? modulus - 1 : q - 1;
    endfunction

endpackage

// File: rtl/jk_counter_bit.sv
// Single JK flip-flop cell with asynchronous active-low clear.
module jk_counter_bit
    import jk_counter_pkg::*;
(
    input  logic clk,
    input  logic clr_bar,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) q_q <= 1'b0;
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-N up/down counter on a bank of JK cells with toggle-only excitation.
// Define JK_SYNC_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module jk_sync_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr_bar,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    always_comb begin
        ld_val = (32'(d_in) >= 32'(MODULUS)) ? MAX_CNT : d_in;
        nxt    = q;
        if (load) begin
            nxt = ld_val;
        end else if (en) begin
`ifdef JK_SYNC_COUNTER_SATURATE_EN
            if (up_down && q == MAX_CNT) begin
                nxt = MAX_CNT;
            end else if (!up_down && q == '0) begin
                nxt = '0;
            end else begin
                nxt = WIDTH'(next_count(32'(q), up_down, 32'(MODULUS)));
            end
`else
            nxt = WIDTH'(next_count(32'(q), up_down, 32'(MODULUS)));
`endif
        end
    end

    // Only hold or toggle is ever issued: a bit toggles iff it changes.
    always_comb begin
        j_vec = q ^ nxt;
        k_vec = q ^ nxt;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_counter_bit u_bit (
            .clk     (clk),
            .clr_bar (clr_bar),
            .j       (j_vec[i]),
            .k       (k_vec[i]),
            .q       (q[i])
        );
    end

    assign tc = en & ~load &
                ((up_down & (q == MAX_CNT)) | (~up_down & (q == '0)));

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (WIDTH=4, MODULUS=10).
// Expectations switch with JK_SYNC_COUNTER_SATURATE_EN.
module tb_jk_sync_counter;

    logic       clk = 1'b0;
    logic       clr_bar;
    logic       en;
    logic       up_down;
    logic       load;
    logic [3:0] d_in;
    logic [3:0] q;
    logic       tc;

    int n_chk  = 0;
    int n_fail = 0;

    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk     (clk),
        .clr_bar (clr_bar),
        .en      (en),
        .up_down (up_down),
        .load    (load),
        .d_in    (d_in),
        .q       (q),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_q;
    logic [3:0] sat_up [4];
    logic [3:0] wrp_up [4];

    initial begin
        clr_bar = 1'b0;
        en      = 1'b0;
        up_down = 1'b1;
        load    = 1'b0;
        d_in    = '0;
        #2;
        check("rst_q", q, 0);
        check("rst_tc_idle", tc, 0);
        en = 1'b1; up_down = 1'b0; #1;
        check("rst_tc_down", tc, 1);
        up_down = 1'b1; #1;
        check("rst_tc_up", tc, 0);
        tick();
        check("rst_hold", q, 0);
        clr_bar = 1'b1;

        // Up count across the wrap
        exp_q = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_q = (exp_q + 1) % 10;
            check("up_q", q, exp_q);
            check("up_tc", tc, (exp_q == 9) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) tick();
        check("up_to7", q, 7);

        // Asynchronous clear between edges
        #2 clr_bar = 1'b0; #1;
        check("clr_async", q, 0);
        tick();
        check("clr_hold", q, 0);
        clr_bar = 1'b1;
        tick();
        check("clr_release", q, 1);

        // Down wrap from 0
        load = 1'b1; d_in = 4'd0; up_down = 1'b0; #1;
        check("ld_tc0", tc, 0);
        tick();
        load = 1'b0; #1;
        check("dn_q0", q, 0);
        check("dn_tc0", tc, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dn_q", q, 9 - i);
            check("dn_tc", tc, 0);
        end

        // Load priority and clamp
        load = 1'b1; up_down = 1'b1; d_in = 4'd13; #1;
        check("ld_clamp_tc", tc, 0);
        tick();
        check("ld_clamp_q", q, 9);
        d_in = 4'd5;
        tick();
        check("ld_5", q, 5);
        d_in = 4'd6;
        tick();
        load = 1'b0; en = 1'b0; #1;

        // Hold: no excitation
        for (int i = 0; i < 5; i++) begin
            check("hold_j", dut.j_vec, 0);
            check("hold_k", dut.k_vec, 0);
            tick();
            check("hold_q", q, 6);
        end

        // 7 -> 8 toggles every bit
        load = 1'b1; d_in = 4'd7;
        tick();
        load = 1'b0; en = 1'b1; up_down = 1'b1; #1;
        check("tgl_j", dut.j_vec, 4'hF);
        check("tgl_k", dut.k_vec, 4'hF);
        tick();
        check("tgl_q", q, 8);

        // Boundary behaviour: wrap or saturate
        sat_up = '{4'd9, 4'd9, 4'd9, 4'd9};
        wrp_up = '{4'd9, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef JK_SYNC_COUNTER_SATURATE_EN
            check("bnd_up_q", q, sat_up[i]);
            check("bnd_up_tc", tc, 1);
`else
            check("bnd_up_q", q, wrp_up[i]);
            check("bnd_up_tc", tc, (i == 0) ? 1 : 0);
`endif
        end
        load = 1'b1; d_in = 4'd1;
        tick();
        load = 1'b0; up_down = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
`ifdef JK_SYNC_COUNTER_SATURATE_EN
            check("bnd_dn_q", q, 0);
            check("bnd_dn_tc", tc, 1);
`else
            check("bnd_dn_q", q, (i == 0) ? 0 : 9);
            check("bnd_dn_tc", tc, (i == 0) ? 1 : 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
Name: jk_sync_counter

Overview:
- Synchronous modulo-N up/down counter built as a bank of JK flip-flop cells with asynchronous clear.
- Per-bit J/K excitation logic computes the next count and drives the JK cells.
- Sits directly upstream of the JK flip-flop stage and is its primary consumer-facing user: it generates every j/k pair the flops see.
- Outputs a count and a terminal-count pulse so digits can be cascaded.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 10: count range 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  clock; all state changes on posedge.
- clr_bar  input  1  asynchronous active-low clear.
- en  input  1  count enable.
- up_down  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- d_in  input  WIDTH  load value.
- q  output  WIDTH  current count, registered (JK cell outputs).
- tc  output  1  terminal count, combinational.

Behaviour:
- Reset:
  - clr_bar low forces q = 0 immediately, independent of clk.
  - tc then follows its equation (tc = 1 if en=1 and up_down=0 while in reset).
  - Releasing clr_bar takes effect at the next posedge.
- Priority at posedge: clr_bar low > load > en > hold.
- Load:
  - q <= d_in next cycle.
  - If d_in >= MODULUS, q <= MODULUS-1 (clamped).
  - Load ignores en and up_down.
- Count, en=1, load=0:
  - Up: q <= q+1; at MODULUS-1 wraps to 0.
  - Down: q <= q-1; at 0 wraps to MODULUS-1.
- Hold: en=0, load=0 -> q unchanged; every cell gets j=k=0.
- Latency: one clock from input sample to updated q.
- Excitation rule (fixed, verifiable): per bit i, with next value n_i:
  - j_i = k_i = q_i XOR n_i (toggle on change, otherwise hold).
  - The JK set/reset encodings are never used.
- Terminal count: tc = en & ~load & ((up_down & q==MODULUS-1) | (~up_down & q==0)).
  - Purely combinational, no register stage.
  - Intended to feed en of the next cascaded digit.
- Illegal state: if q >= MODULUS (reachable only via X or glitch), the next enabled count goes to 0 in either direction. tc = 0 in that state.
- Direction change mid-count takes effect on the same edge it is sampled. No pipeline.
- Simultaneous load and en: load wins; tc = 0.

Optional Feature:
- Macro: JK_SYNC_COUNTER_SATURATE_EN.
- Defined:
  - Counting up at MODULUS-1 holds at MODULUS-1.
  - Counting down at 0 holds at 0.
  - tc is still asserted at the boundary.
  - Load is unaffected.
- Undefined: wrap-around as specified above.

Decomposition:
- Package jk_counter_pkg:
  - JK command constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - Helper function next_count(q, up_down, modulus) returning the wrapped value.
- Sub-module jk_counter_bit: one JK cell with async clear, instantiated WIDTH times via generate.
- Next-state and excitation logic stay in the top level.

Test Plan:
- Reset mid-count: count to 7, pulse clr_bar low between edges -> q = 0 immediately, holds at 0 until clr_bar high, then 1 after the first enabled up edge.
- Up wrap, MODULUS=10: en=1, up_down=1 for 12 clocks from 0 -> q = 1..9,0,1,2; tc high only while q = 9.
- Down wrap: en=1, up_down=0 from q = 0 -> q = 9,8,7; tc high while q = 0.
- Load priority and clamp: load=1, en=1, d_in=4'd13 -> q = 9, tc = 0 during load. Then d_in=4'd5 -> q = 5.
- Hold and excitation: en=0 for 5 cycles at q = 6 -> q stays 6; internal j/k = 0 on all bits. Enable up from 7 -> bits 0..3 toggle (j=k=1 on all four), q = 8.
- Saturate build (JK_SYNC_COUNTER_SATURATE_EN): up from 8 for 4 clocks -> q = 9,9,9,9 with tc = 1. Down from 1 -> q = 0,0 with tc = 1.
